// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: the control state
// encoding and the bit-counter width helper.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A width-1 operand still needs a one-bit counter, so $clog2 is floored at 1
   function automatic int CNT_W(input int data_width);
      return (data_width <= 1) ? 1 : $clog2(data_width);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] diff,
   output logic                  bout
);

   localparam int            CW   = CNT_W(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] a_sr;
   logic [DATA_WIDTH-1:0] b_sr;
   logic [DATA_WIDTH-1:0] res_sr;
   logic [DATA_WIDTH-1:0] res_next;
   logic [DATA_WIDTH-1:0] diff_q;
   logic                  br_q;
   logic                  bout_q;
   logic                  bit_diff;
   logic                  bit_bout;
   logic [CW-1:0]         cnt_q;
   logic                  last_bit;

   full_subtractor u_full_subtractor (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br_q),
      .diff (bit_diff),
      .bout (bit_bout)
   );

   assign last_bit = (cnt_q == LAST);

   // New diff bits enter at the MSB so after DATA_WIDTH shifts bit 0 lands at the LSB
   assign res_next = (res_sr >> 1) | (DATA_WIDTH'(bit_diff) << (DATA_WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_bit)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operands are sampled only at the accept edge; the result registers load
   // only on the final RUN edge so they stay stable through DONE and beyond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br_q   <= 1'b0;
         cnt_q  <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  br_q  <= bin;
                  cnt_q <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               br_q   <= bit_bout;
               res_sr <= res_next;
               cnt_q  <= cnt_q + CW'(1);
               if (last_bit) begin
                  diff_q <= res_next;
                  bout_q <= bit_bout;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at widths 4, 1 and 16, with a small
// reference model for the random back-to-back run.
module tb_serial_subtractor;

   logic clk;
   logic rst_n;

   logic        in_valid4, in_ready4, bin4, out_valid4, out_ready4, bout4;
   logic [3:0]  a4, b4, diff4;
   logic        in_valid1, in_ready1, bin1, out_valid1, out_ready1, bout1;
   logic [0:0]  a1, b1, diff1;
   logic        in_valid16, in_ready16, bin16, out_valid16, out_ready16, bout16;
   logic [15:0] a16, b16, diff16;

   int passCount;
   int checkCount;

   serial_subtractor #(.DATA_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .diff(diff4), .bout(bout4)
   );

   serial_subtractor #(.DATA_WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .diff(diff1), .bout(bout1)
   );

   serial_subtractor #(.DATA_WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .bin(bin16), .out_valid(out_valid16), .out_ready(out_ready16),
      .diff(diff16), .bout(bout16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one 4-bit operation through to its output handshake, holding
   // out_ready low for 'stall' cycles once the result is presented.
   task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic binv,
                                input int stall, output logic [3:0] dv, output logic bov,
                                output int lat, output bit timedOut);
      int n;
      timedOut = 1'b0;
      @(negedge clk);
      a4 = av; b4 = bv; bin4 = binv; in_valid4 = 1'b1; out_ready4 = 1'b0;
      n = 0;
      while (!in_ready4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timedOut = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid4 = 1'b0; a4 = ~av; b4 = ~bv; bin4 = ~binv;
      lat = 0;
      while (!out_valid4 && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!out_valid4) timedOut = 1'b1;
      repeat (stall) @(negedge clk);
      dv = diff4; bov = bout4;
      out_ready4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready4 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checkCount++;
      if ({in_ready4, out_valid4, bout4, diff4} !== 7'b1000000)
         $display("[TB] FAIL reset4: got rdy/vld/bout/diff=%b required 1000000", {in_ready4, out_valid4, bout4, diff4});
      else passCount++;
      checkCount++;
      if ({in_ready1, out_valid1, bout1, diff1} !== 4'b1000)
         $display("[TB] FAIL reset1: got %b required 1000", {in_ready1, out_valid1, bout1, diff1});
      else passCount++;
      checkCount++;
      if ({in_ready16, out_valid16, bout16, diff16} !== {3'b100, 16'h0000})
         $display("[TB] FAIL reset16: got rdy=%b vld=%b bout=%b diff=%h", in_ready16, out_valid16, bout16, diff16);
      else passCount++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [3:0] av [4] = '{4'd5, 4'd3, 4'd0, 4'd9};
      logic [3:0] bv [4] = '{4'd3, 4'd5, 4'd0, 4'd9};
      logic       cv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] ed [4] = '{4'h2, 4'hE, 4'hF, 4'h0};
      logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [3:0] dv;
      logic       bov;
      int         lat;
      bit         to;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(av[i], bv[i], cv[i], 0, dv, bov, lat, to);
         checkCount++;
         if (to) $display("[TB] FAIL basic%0d_timeout: handshake did not complete", i);
         else passCount++;
         checkCount++;
         if (lat !== 4) $display("[TB] FAIL basic%0d_latency: got %0d edges required 4", i, lat);
         else passCount++;
         checkCount++;
         if ({bov, dv} !== {eb[i], ed[i]})
            $display("[TB] FAIL basic%0d_result: got bout=%b diff=%h required bout=%b diff=%h", i, bov, dv, eb[i], ed[i]);
         else passCount++;
         checkCount++;
         if ({in_ready4, out_valid4} !== 2'b10)
            $display("[TB] FAIL basic%0d_idle: got in_ready=%b out_valid=%b required 1 0", i, in_ready4, out_valid4);
         else passCount++;
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      a4 = 4'd12; b4 = 4'd7; bin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkCount++;
      if (!out_valid4) $display("[TB] FAIL bp_timeout: out_valid=%b required 1", out_valid4);
      else passCount++;
      for (int i = 0; i < 10; i++) begin
         in_valid4 = i[0]; a4 = 4'(i); b4 = 4'(15 - i); bin4 = i[1];
         @(negedge clk);
         checkCount++;
         if ({out_valid4, in_ready4, bout4, diff4} !== {3'b100, 4'd5})
            $display("[TB] FAIL bp_hold%0d: got vld=%b rdy=%b bout=%b diff=%h required 1 0 0 5", i, out_valid4, in_ready4, bout4, diff4);
         else passCount++;
      end
      in_valid4 = 1'b0; out_ready4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready4 = 1'b0;
      checkCount++;
      if ({in_ready4, out_valid4} !== 2'b10)
         $display("[TB] FAIL bp_release: got rdy=%b vld=%b required 1 0", in_ready4, out_valid4);
      else passCount++;
      repeat (6) @(negedge clk);
      checkCount++;
      if ({in_ready4, out_valid4} !== 2'b10)
         $display("[TB] FAIL bp_no_phantom: got rdy=%b vld=%b required 1 0", in_ready4, out_valid4);
      else passCount++;
   endtask

   task automatic test_reset_midop();
      logic [3:0] dv;
      logic       bov;
      int         lat;
      bit         to;
      @(negedge clk);
      a4 = 4'd5; b4 = 4'd3; bin4 = 1'b0; in_valid4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid4 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkCount++;
      if ({in_ready4, out_valid4, bout4, diff4} !== 7'b1000000)
         $display("[TB] FAIL midop_reset: got rdy/vld/bout/diff=%b required 1000000", {in_ready4, out_valid4, bout4, diff4});
      else passCount++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkCount++;
      if (out_valid4 !== 1'b0) $display("[TB] FAIL midop_discard: got out_valid=%b required 0", out_valid4);
      else passCount++;
      applyStimulus(4'd1, 4'd1, 1'b0, 0, dv, bov, lat, to);
      checkCount++;
      if (to || lat !== 4 || {bov, dv} !== 5'b00000)
         $display("[TB] FAIL midop_next: got to=%0d lat=%0d bout=%b diff=%h required 0 4 0 0", to, lat, bov, dv);
      else passCount++;
   endtask

   task automatic test_width1();
      int lat;
      @(negedge clk);
      a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkCount++;
      if (lat !== 1 || {bout1, diff1} !== 2'b11)
         $display("[TB] FAIL width1: got lat=%0d bout=%b diff=%b required 1 1 1", lat, bout1, diff1);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if ({in_ready1, out_valid1} !== 2'b10)
         $display("[TB] FAIL width1_idle: got rdy=%b vld=%b required 1 0", in_ready1, out_valid1);
      else passCount++;
   endtask

   task automatic test_width16();
      int lat;
      @(negedge clk);
      a16 = 16'h8000; b16 = 16'h0001; bin16 = 1'b1; in_valid16 = 1'b1; out_ready16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid16 = 1'b0; a16 = 16'hFFFF;
      lat = 0;
      while (!out_valid16 && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkCount++;
      if (lat !== 16 || bout16 !== 1'b0 || diff16 !== 16'h7FFE)
         $display("[TB] FAIL width16: got lat=%0d bout=%b diff=%h required 16 0 7ffe", lat, bout16, diff16);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] av, bv, dv;
      logic       cv, bov;
      logic [4:0] model;
      int         lat;
      bit         to;
      for (int i = 0; i < 24; i++) begin
         av = 4'($urandom_range(0, 15));
         bv = 4'($urandom_range(0, 15));
         cv = 1'($urandom_range(0, 1));
         model = {1'b0, av} - {1'b0, bv} - {4'b0000, cv};
         applyStimulus(av, bv, cv, int'($urandom_range(0, 3)), dv, bov, lat, to);
         checkCount++;
         if (to || lat !== 4 || {bov, dv} !== model)
            $display("[TB] FAIL b2b%0d: a=%h b=%h bin=%b got to=%0d lat=%0d bout=%b diff=%h required lat=4 bout=%b diff=%h",
                     i, av, bv, cv, to, lat, bov, dv, model[4], model[3:0]);
         else passCount++;
         checkCount++;
         if (out_valid4 !== 1'b0) $display("[TB] FAIL b2b%0d_single: got out_valid=%b required 0", i, out_valid4);
         else passCount++;
      end
   endtask

   initial begin
      passCount = 0; checkCount = 0;
      in_valid4 = 0; a4 = '0; b4 = '0; bin4 = 0; out_ready4 = 0;
      in_valid1 = 0; a1 = '0; b1 = '0; bin1 = 0; out_ready1 = 0;
      in_valid16 = 0; a16 = '0; b16 = '0; bin16 = 0; out_ready16 = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_midop();
      test_width1();
      test_width16();
      test_back_to_back();
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
